nms_window_ctrl: RTL and testbench

Sequencer for the non-maximum-suppression stage. Accepts a raster stream of gradient magnitudes and direction codes, and buffers two image lines. It builds a zero-padded 3x3 kernel with the centre pixel's direction and presents one kernel per image pixel to the NMS datapath. The NMS datapath has a 1-cycle registered output. The block also produces the matching output-valid, coordinates and end-of-frame flags for that registered output.

---
 rtl/nms_window_ctrl.sv | 173 +++++++++++++++++
 tb/tb_nms_window_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nms_window_ctrl.sv
// rtl/nms_window_ctrl.sv - NMS window sequencer: two line buffers, zero-padded 3x3 kernel, output flags
module nms_window_ctrl #(
    parameter int NBIT_INPUT = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_valid,
    output logic                            o_ready,
    input  logic [NBIT_INPUT-1:0]           i_mag,
    input  logic [1:0]                      i_dir,
    output logic [9*NBIT_INPUT-1:0]         o_kernel,
    output logic [1:0]                      o_direction,
    output logic                            o_win_valid,
    output logic [$clog2(IMG_HEIGHT)-1:0]   o_row,
    output logic [$clog2(IMG_WIDTH)-1:0]    o_col,
    output logic                            o_nms_valid,
    output logic                            o_frame_done
);

    localparam int N     = NBIT_INPUT;
    localparam int RW    = $clog2(IMG_HEIGHT + 1);
    localparam int CW    = $clog2(IMG_WIDTH + 1);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam int COL_W = $clog2(IMG_WIDTH);

    localparam logic [CW-1:0]    C_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0]    C_PAD   = CW'(IMG_WIDTH);
    localparam logic [RW-1:0]    R_LAST  = RW'(IMG_HEIGHT - 1);
    localparam logic [RW-1:0]    R_FLUSH = RW'(IMG_HEIGHT);
    localparam logic [ROW_W-1:0] O_ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] O_COL_LAST = COL_W'(IMG_WIDTH - 1);

    typedef enum logic [1:0] {S_RUN, S_PAD, S_FLUSH, S_DONE} state_t;

    state_t        state;
    logic [RW-1:0] rs;
    logic [CW-1:0] cs;

    logic [N-1:0] lb1_mag [0:IMG_WIDTH];
    logic [1:0]   lb1_dir [0:IMG_WIDTH];
    logic [N-1:0] lb2_mag [0:IMG_WIDTH];

    logic [N-1:0] win [0:2][0:2];
    logic [1:0]   dir_c;
    logic [1:0]   dir_r;

    logic         push;
    logic         emit;
    logic [N-1:0] push_mag;
    logic [1:0]   push_dir;
    logic [N-1:0] rd1_mag;
    logic [N-1:0] rd2_mag;
    logic [1:0]   rd1_dir;

    always_comb begin
        push     = 1'b0;
        push_mag = '0;
        push_dir = '0;
        case (state)
            S_RUN: begin
                push     = i_valid;
                push_mag = i_mag;
                push_dir = i_dir;
            end
            S_PAD, S_FLUSH: push = 1'b1;
            default:        push = 1'b0;
        endcase
    end

    // Rows above the frame read as zero; also masks unreset buffer contents after reset.
    always_comb begin
        rd1_mag = (rs == '0) ? '0 : lb1_mag[cs];
        rd1_dir = (rs == '0) ? '0 : lb1_dir[cs];
        rd2_mag = (rs <= RW'(1)) ? '0 : lb2_mag[cs];
        emit    = push && (rs != '0) && (cs != '0);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            lb1_mag[cs] <= push_mag;
            lb1_dir[cs] <= push_dir;
            lb2_mag[cs] <= rd1_mag;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= S_RUN;
            o_ready      <= 1'b1;
            rs           <= '0;
            cs           <= '0;
            dir_c        <= '0;
            dir_r        <= '0;
            o_win_valid  <= 1'b0;
            o_row        <= '0;
            o_col        <= '0;
            o_nms_valid  <= 1'b0;
            o_frame_done <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
        end else begin
            o_nms_valid  <= o_win_valid;
            o_frame_done <= o_win_valid && (o_row == O_ROW_LAST) && (o_col == O_COL_LAST);
            o_win_valid  <= emit;

            if (push) begin
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 2; c++)
                        win[r][c] <= win[r][c+1];
                win[0][2] <= rd2_mag;
                win[1][2] <= rd1_mag;
                win[2][2] <= push_mag;
                dir_c     <= dir_r;
                dir_r     <= rd1_dir;
            end

            if (emit) begin
                o_row <= ROW_W'(rs - 1'b1);
                o_col <= COL_W'(cs - 1'b1);
            end

            case (state)
                S_RUN: begin
                    if (i_valid) begin
                        if (cs == C_LAST) begin
                            cs      <= C_PAD;
                            state   <= S_PAD;
                            o_ready <= 1'b0;
                        end else begin
                            cs <= cs + 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    cs <= '0;
                    if (rs == R_LAST) begin
                        rs    <= R_FLUSH;
                        state <= S_FLUSH;
                    end else begin
                        rs      <= rs + 1'b1;
                        state   <= S_RUN;
                        o_ready <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (cs == C_PAD)
                        state <= S_DONE;
                    else
                        cs <= cs + 1'b1;
                end
                default: begin
                    rs      <= '0;
                    cs      <= '0;
                    state   <= S_RUN;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_direction = dir_c;

    always_comb begin
        o_kernel = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                o_kernel[(3*r+c)*N +: N] = win[r][c];
    end

endmodule

// File: tb/tb_nms_window_ctrl.sv
// tb/tb_nms_window_ctrl.sv - randomized self-checking bench for nms_window_ctrl against a padded-image model
module tb_nms_window_ctrl;

    localparam int W = 4;
    localparam int H = 3;
    localparam int N = 12;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [N-1:0]    i_mag = '0;
    logic [1:0]      i_dir = '0;
    logic [9*N-1:0]  o_kernel;
    logic [1:0]      o_direction;
    logic            o_win_valid;
    logic [1:0]      o_row;
    logic [1:0]      o_col;
    logic            o_nms_valid;
    logic            o_frame_done;

    nms_window_ctrl #(.NBIT_INPUT(N), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_mag(i_mag), .i_dir(i_dir), .o_kernel(o_kernel), .o_direction(o_direction),
        .o_win_valid(o_win_valid), .o_row(o_row), .o_col(o_col),
        .o_nms_valid(o_nms_valid), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [9*N-1:0] k;
        logic [1:0]     d;
        int             r;
        int             c;
        int             f;
        bit             last;
    } win_t;

    int   vectors = 0;
    int   miscompares = 0;
    int   fm_mag [H][W];
    int   fm_dir [H][W];
    win_t expq [$];
    bit   mon_en = 1'b0;
    bit   prev_win = 1'b0;
    bit   prev_last = 1'b0;
    bit   nms_tgt = 1'b0;
    int   nms_out = 0;
    int   nms_want = 0;
    logic [9*N-1:0] cap00 = '0;
    logic [9*N-1:0] cap13 = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9*N-1:0] pk(input int v0, v1, v2, v3, v4, v5, v6, v7, v8);
        logic [9*N-1:0] k;
        int v [9];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7, v8};
        for (int i = 0; i < 9; i++) k[i*N +: N] = v[i][N-1:0];
        return k;
    endfunction

    // Suppress the centre unless it is at least as large as both neighbours along the gradient.
    function automatic int nms_ref(input logic [9*N-1:0] k, input logic [1:0] d);
        int e [9];
        int a, b;
        for (int i = 0; i < 9; i++) e[i] = int'(k[i*N +: N]);
        case (d)
            2'b00: begin a = e[3]; b = e[5]; end
            2'b01: begin a = e[2]; b = e[6]; end
            2'b10: begin a = e[1]; b = e[7]; end
            default: begin a = e[0]; b = e[8]; end
        endcase
        return (e[4] >= a && e[4] >= b) ? e[4] : 0;
    endfunction

    function automatic void build_exp(input int f);
        win_t e;
        int y, x, val;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                e.k = '0;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++) begin
                        y = r - 1 + rr;
                        x = c - 1 + cc;
                        val = (y >= 0 && y < H && x >= 0 && x < W) ? fm_mag[y][x] : 0;
                        e.k[(3*rr+cc)*N +: N] = val[N-1:0];
                    end
                e.d    = fm_dir[r][c][1:0];
                e.r    = r;
                e.c    = c;
                e.f    = f;
                e.last = (r == H-1) && (c == W-1);
                expq.push_back(e);
            end
    endfunction

    always @(negedge i_clk) begin
        win_t e;
        if (!i_rst_n) begin
            prev_win  = 1'b0;
            prev_last = 1'b0;
            nms_tgt   = 1'b0;
        end else if (mon_en) begin
            check("nms_valid", o_nms_valid, prev_win);
            check("frame_done", o_frame_done, prev_win & prev_last);
            if (o_nms_valid && nms_tgt) check("nms_out", nms_out, nms_want);
            nms_tgt   = 1'b0;
            prev_last = 1'b0;
            if (o_win_valid) begin
                vectors++;
                if (expq.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_window: got window row %0d col %0d, want none", o_row, o_col);
                end else begin
                    e = expq.pop_front();
                    check("kernel", o_kernel, e.k);
                    check("direction", o_direction, e.d);
                    check("row", o_row, e.r);
                    check("col", o_col, e.c);
                    prev_last = e.last;
                    if (e.f == 0 && e.r == 0 && e.c == 0) cap00 = o_kernel;
                    if (e.f == 0 && e.r == 1 && e.c == 3) cap13 = o_kernel;
                    if (e.f == 5 && ((e.r == 1 && e.c == 1) || (e.r == 0 && e.c == 2))) begin
                        nms_tgt  = 1'b1;
                        nms_want = (e.c == 1) ? 0 : 77;
                        nms_out  = nms_ref(o_kernel, o_direction);
                    end
                end
            end
            prev_win = o_win_valid;
        end
    end

    // stop >= 0: return right after that many accepted pixels, without queueing expectations.
    task automatic drive_frame(input int f, input int pct, input int stop);
        int n = 0;
        int tries;
        bit v;
        bit acc;
        int gap;
        if (stop < 0) build_exp(f);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                acc = 1'b0;
                tries = 0;
                while (!acc) begin
                    v = ($urandom_range(99) < pct) || (tries > 20);
                    i_valid = v;
                    i_mag   = fm_mag[r][c][N-1:0];
                    i_dir   = fm_dir[r][c][1:0];
                    check("ready_run", o_ready, 1);
                    @(posedge i_clk); #1;
                    acc = v;
                    tries++;
                end
                n++;
                if (n == stop) return;
                if (c == W-1) begin
                    gap = (r == H-1) ? W + 3 : 1;
                    for (int g = 0; g < gap; g++) begin
                        i_valid = 1'($urandom_range(1));
                        i_mag   = N'($urandom);
                        check("ready_gap", o_ready, 0);
                        @(posedge i_clk); #1;
                    end
                end
            end
        i_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        i_valid = 1'b0;
        repeat (n) begin @(posedge i_clk); #1; end
    endtask

    task automatic fill_ramp(input int base, input int d);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fm_mag[r][c] = base + r*W + c + 1;
                fm_dir[r][c] = d;
            end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_win_valid"}, o_win_valid, 0);
        check({tag, "_nms_valid"}, o_nms_valid, 0);
        check({tag, "_frame_done"}, o_frame_done, 0);
        check({tag, "_ready"}, o_ready, 1);
        check({tag, "_kernel"}, o_kernel, 0);
        check({tag, "_dir_row_col"}, {o_direction, o_row, o_col}, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        check_idle("reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        #1;
        check_idle("release");
        mon_en = 1'b1;

        fill_ramp(0, 2);
        drive_frame(0, 100, -1);
        drain(4);
        check("lit_win00", cap00, pk(0, 0, 0, 0, 1, 2, 0, 5, 6));
        check("lit_win13", cap13, pk(3, 4, 0, 7, 8, 0, 11, 12, 0));

        mon_en = 1'b0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fm_mag[r][c] = int'($urandom_range(4095));
                fm_dir[r][c] = int'($urandom_range(3));
            end
        drive_frame(9, 100, W + 2);
        #2 i_rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        mon_en = 1'b1;

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fm_mag[r][c] = int'($urandom_range(4095));
                fm_dir[r][c] = c % 4;
            end
        drive_frame(1, 100, -1);

        fill_ramp(0, 2);
        drive_frame(2, 50, -1);

        fill_ramp(0, 1);
        drive_frame(3, 100, -1);
        fill_ramp(100, 3);
        drive_frame(4, 60, -1);

        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                fm_mag[r][c] = int'($urandom_range(30));
                fm_dir[r][c] = int'($urandom_range(3));
            end
        fm_mag[1][0] = 40; fm_mag[1][1] = 50; fm_mag[1][2] = 60; fm_dir[1][1] = 0;
        fm_mag[0][1] = 10; fm_mag[0][2] = 77; fm_mag[0][3] = 20; fm_dir[0][2] = 0;
        drive_frame(5, 80, -1);
        drain(5);

        check("all_windows_seen", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
